// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory request controller.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} mem_ctrl_state_t;

    localparam int unsigned MEM_DEPTH   = 256;
    localparam int unsigned MEM_WIDTH   = 32;
    localparam int unsigned MEM_LATENCY = 2;

    // Wide enough for the largest supported read latency (15).
    localparam int unsigned MEM_CNT_W   = 4;

endpackage

// File: rtl/mem_req_ctrl.sv
// Sequences single read/write requests onto a dual-address memory port and
// returns read data, after a fixed read latency, on a valid/ready channel.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned N       = MEM_DEPTH,
    parameter int unsigned M       = MEM_WIDTH,
    parameter int unsigned LATENCY = MEM_LATENCY,
    localparam int unsigned AW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [M-1:0]  req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [M-1:0]  rsp_rdata,
    output logic          mem_write_enable,
    output logic [AW-1:0] mem_write_addr,
    output logic [M-1:0]  mem_write_data,
    output logic          mem_read_enable,
    output logic [AW-1:0] mem_read_addr,
    input  logic [M-1:0]  mem_read_data,
    output logic          busy
);

    localparam int unsigned CNT_W = MEM_CNT_W;

    if (LATENCY == 0 || LATENCY > 15) begin : g_bad_latency
        $error("mem_req_ctrl: LATENCY must be in the range 1..15");
    end

    mem_ctrl_state_t r_state;
    mem_ctrl_state_t w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [AW-1:0]    r_wr_addr;
    logic [AW-1:0]    w_wr_addr_nxt;
    logic [M-1:0]     r_wr_data;
    logic [M-1:0]     w_wr_data_nxt;
    logic [AW-1:0]    r_rd_addr;
    logic [AW-1:0]    w_rd_addr_nxt;
    logic [M-1:0]     r_rdata;
    logic [M-1:0]     w_rdata_nxt;

    logic r_idle;
    logic r_busy;
    logic r_mem_we;
    logic r_mem_re;
    logic r_rsp_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and holding-register updates.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_rd_addr_nxt = r_rd_addr;
        w_rdata_nxt   = r_rdata;
        case (r_state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_we) begin
                        w_wr_addr_nxt = req_addr;
                        w_wr_data_nxt = req_wdata;
                        w_state_nxt   = WRITE;
                    end else begin
                        w_rd_addr_nxt = req_addr;
                        w_cnt_nxt     = CNT_W'(LATENCY - 1);
                        w_state_nxt   = READ;
                    end
                end
            end
            WRITE: begin
                w_state_nxt = IDLE;
            end
            READ: begin
                if (r_cnt == '0) begin
                    w_rdata_nxt = mem_read_data;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers plus strobes decoded one edge early so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_addr   <= '0;
            r_rdata     <= '0;
            r_idle      <= 1'b1;
            r_busy      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_rdata     <= w_rdata_nxt;
            r_idle      <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_mem_we    <= (w_state_nxt == WRITE);
            r_mem_re    <= (w_state_nxt == READ);
            r_rsp_valid <= (w_state_nxt == RESP);
        end
    end

    // Ready must fall with rst itself, not at the next edge.
    assign req_ready        = r_idle & ~rst;
    assign busy             = r_busy;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_rdata        = r_rdata;
    assign mem_write_enable = r_mem_we;
    assign mem_write_addr   = r_wr_addr;
    assign mem_write_data   = r_wr_data;
    assign mem_read_enable  = r_mem_re;
    assign mem_read_addr    = r_rd_addr;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: a LATENCY=2 controller with a memory
// model, plus LATENCY=1 and LATENCY=4 controllers for throughput spacing.
module tb_mem_req_ctrl;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        mem_write_enable;
    logic [7:0]  mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_read_enable;
    logic [7:0]  mem_read_addr;
    logic [31:0] mem_read_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cnt = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] mem_arr [256];
    logic [31:0] rd_pipe;

    mem_req_ctrl #(.N(256), .M(32), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read_enable(mem_read_enable),
        .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .busy(busy)
    );

    // Memory instance: one output register gives a two-cycle read latency.
    always @(posedge clk) begin
        if (mem_write_enable) mem_arr[mem_write_addr] <= mem_write_data;
        rd_pipe <= mem_arr[mem_read_addr];
    end
    assign mem_read_data = rd_pipe;

    // Throughput instances, fed by a combinational address-derived memory.
    logic        fr_go;
    logic [7:0]  fr_addr;
    logic        l1_ready, l1_rv, l1_we, l1_re, l1_busy;
    logic [31:0] l1_rdata, l1_wd, l1_md;
    logic [7:0]  l1_wa, l1_ra;
    logic        l4_ready, l4_rv, l4_we, l4_re, l4_busy;
    logic [31:0] l4_rdata, l4_wd, l4_md;
    logic [7:0]  l4_wa, l4_ra;

    function automatic logic [31:0] fmem(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    assign l1_md = fmem(l1_ra);
    assign l4_md = fmem(l4_ra);

    mem_req_ctrl #(.N(256), .M(32), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .req_valid(fr_go), .req_ready(l1_ready), .req_we(1'b0),
        .req_addr(fr_addr), .req_wdata(32'h0),
        .rsp_valid(l1_rv), .rsp_ready(1'b1), .rsp_rdata(l1_rdata),
        .mem_write_enable(l1_we), .mem_write_addr(l1_wa),
        .mem_write_data(l1_wd), .mem_read_enable(l1_re),
        .mem_read_addr(l1_ra), .mem_read_data(l1_md),
        .busy(l1_busy)
    );

    mem_req_ctrl #(.N(256), .M(32), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst),
        .req_valid(fr_go), .req_ready(l4_ready), .req_we(1'b0),
        .req_addr(fr_addr), .req_wdata(32'h0),
        .rsp_valid(l4_rv), .rsp_ready(1'b1), .rsp_rdata(l4_rdata),
        .mem_write_enable(l4_we), .mem_write_addr(l4_wa),
        .mem_write_data(l4_wd), .mem_read_enable(l4_re),
        .mem_read_addr(l4_ra), .mem_read_data(l4_md),
        .busy(l4_busy)
    );

    int          acc_cyc  [2][32];
    logic [7:0]  acc_addr [2][32];
    logic [31:0] rsp_d    [2][32];
    int          acc_n    [2] = '{0, 0};
    int          rsp_n    [2] = '{0, 0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event recorder: handshakes on the main DUT, accepts/responses on the others.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;
        if (fr_go && l1_ready && acc_n[0] < 32) begin
            acc_cyc[0][acc_n[0]]  <= cyc;
            acc_addr[0][acc_n[0]] <= fr_addr;
            acc_n[0]              <= acc_n[0] + 1;
        end
        if (fr_go && l4_ready && acc_n[1] < 32) begin
            acc_cyc[1][acc_n[1]]  <= cyc;
            acc_addr[1][acc_n[1]] <= fr_addr;
            acc_n[1]              <= acc_n[1] + 1;
        end
        if (l1_rv && rsp_n[0] < 32) begin
            rsp_d[0][rsp_n[0]] <= l1_rdata;
            rsp_n[0]           <= rsp_n[0] + 1;
        end
        if (l4_rv && rsp_n[1] < 32) begin
            rsp_d[1][rsp_n[1]] <= l4_rdata;
            rsp_n[1]           <= rsp_n[1] + 1;
        end
    end

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        checks++;
        if ({req_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL wr_idle got ready/busy=%b exp 10", {req_ready, busy});
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'($urandom); req_we = 1'($urandom);
        req_addr = 8'($urandom); req_wdata = $urandom;
        checks++;
        if ({mem_write_enable, mem_read_enable, rsp_valid, busy, req_ready} !== 5'b10010 ||
            mem_write_addr !== a || mem_write_data !== d) begin
            errors++;
            $display("FAIL wr_cycle got we/re/rv/busy/rdy=%b addr=%h data=%h exp 10010 %h %h",
                     {mem_write_enable, mem_read_enable, rsp_valid, busy, req_ready},
                     mem_write_addr, mem_write_data, a, d);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if ({mem_write_enable, busy, req_ready} !== 3'b001 ||
            mem_write_addr !== a || mem_write_data !== d) begin
            errors++;
            $display("FAIL wr_done got we/busy/rdy=%b addr=%h data=%h exp 001 %h %h",
                     {mem_write_enable, busy, req_ready}, mem_write_addr, mem_write_data, a, d);
        end
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [7:0] a, input int bp);
        logic [31:0] exp;
        int h0;
        exp = ref_mem[a];
        checks++;
        if ({req_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL rd_idle got ready/busy=%b exp 10", {req_ready, busy});
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = $urandom;
        @(posedge clk); #1;
        for (int i = 0; i < int'(LAT); i++) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = 8'($urandom);
            rsp_ready = 1'($urandom);
            checks++;
            if ({mem_read_enable, mem_write_enable, rsp_valid, busy, req_ready} !== 5'b10010 ||
                mem_read_addr !== a) begin
                errors++;
                $display("FAIL rd_phase%0d got re/we/rv/busy/rdy=%b addr=%h exp 10010 %h", i,
                         {mem_read_enable, mem_write_enable, rsp_valid, busy, req_ready},
                         mem_read_addr, a);
            end
            @(posedge clk); #1;
        end
        for (int b = 0; b <= bp; b++) begin
            rsp_ready = (b == bp);
            req_valid = 1'($urandom); req_we = 1'($urandom);
            checks++;
            if ({rsp_valid, mem_read_enable, busy, req_ready} !== 4'b1010 || rsp_rdata !== exp) begin
                errors++;
                $display("FAIL rd_resp%0d got rv/re/busy/rdy=%b data=%h exp 1010 %h", b,
                         {rsp_valid, mem_read_enable, busy, req_ready}, rsp_rdata, exp);
            end
            h0 = hs_cnt;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0; req_valid = 1'b0;
        checks++;
        if ({rsp_valid, busy, req_ready} !== 3'b001 || hs_cnt !== h0 + 1 ||
            rsp_rdata !== exp || mem_read_addr !== a) begin
            errors++;
            $display("FAIL rd_done got rv/busy/rdy=%b hs=%0d data=%h addr=%h exp 001 %0d %h %h",
                     {rsp_valid, busy, req_ready}, hs_cnt, rsp_rdata, mem_read_addr, h0 + 1, exp, a);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, mem_write_enable, mem_read_enable} !== 5'b0 ||
            rsp_rdata !== 32'h0 || mem_write_addr !== 8'h0 || mem_write_data !== 32'h0 ||
            mem_read_addr !== 8'h0) begin
            errors++; $display("FAIL reset_vals got rdy/rv/busy/we/re=%b data=%h exp 00000 0",
                               {req_ready, rsp_valid, busy, mem_write_enable, mem_read_enable}, rsp_rdata);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if ({req_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL reset_release got ready/busy=%b exp 10", {req_ready, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        do_write(8'h10, 32'hDEADBEEF);
        do_read(8'h10, 0);
    endtask

    task automatic test_backpressure();
        do_read(8'h05, 3);
    endtask

    task automatic test_boundary();
        do_write(8'hFF, 32'hA5A5A5A5);
        do_write(8'h00, 32'h5A5A5A5A);
        do_read(8'hFF, 1);
        do_read(8'h00, 0);
    endtask

    task automatic test_reset_async();
        int h0;
        do_write(8'h33, 32'hCAFEF00D);
        h0 = hs_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h33;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL rst_pre got rv=%b data=%h exp 1 cafef00d", rsp_valid, rsp_rdata);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, mem_write_enable, mem_read_enable} !== 5'b0 ||
            rsp_rdata !== 32'h0 || mem_write_addr !== 8'h0 || mem_write_data !== 32'h0 ||
            mem_read_addr !== 8'h0) begin
            errors++;
            $display("FAIL rst_async got rdy/rv/busy/we/re=%b data=%h waddr=%h wdata=%h raddr=%h exp all 0",
                     {req_ready, rsp_valid, busy, mem_write_enable, mem_read_enable},
                     rsp_rdata, mem_write_addr, mem_write_data, mem_read_addr);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if ({req_ready, busy} !== 2'b10 || hs_cnt !== h0) begin
            errors++; $display("FAIL rst_async_rel got ready/busy=%b hs=%0d exp 10 %0d",
                               {req_ready, busy}, hs_cnt, h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        int h0;
        logic seen_rv;
        h0 = hs_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({mem_read_enable, busy} !== 2'b11) begin
            errors++; $display("FAIL mid_read_pre got re/busy=%b exp 11", {mem_read_enable, busy});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_read_enable, busy, rsp_valid, req_ready} !== 4'b0) begin
            errors++; $display("FAIL mid_read_rst got re/busy/rv/rdy=%b exp 0000",
                               {mem_read_enable, busy, rsp_valid, req_ready});
        end
        @(negedge clk); rst = 1'b0;
        seen_rv = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen_rv = seen_rv | rsp_valid;
        end
        checks++;
        if (seen_rv !== 1'b0 || hs_cnt !== h0) begin
            errors++; $display("FAIL mid_read_norsp got rv_seen=%b hs=%0d exp 0 %0d", seen_rv, hs_cnt, h0);
        end
        do_read(8'h10, 0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 8'h00;
                1:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
            else                           do_read(a, $urandom_range(0, 3));
        end
    endtask

    task automatic test_latency_builds();
        int lat_b [2] = '{1, 4};
        fr_go = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            fr_addr = 8'($urandom);
        end
        fr_go = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (acc_n[b] < 40 / (lat_b[b] + 2) - 1 || rsp_n[b] !== acc_n[b]) begin
                errors++; $display("FAIL lat%0d_counts got acc=%0d rsp=%0d exp acc>=%0d rsp==acc",
                                   lat_b[b], acc_n[b], rsp_n[b], 40 / (lat_b[b] + 2) - 1);
            end
            for (int k = 1; k < acc_n[b]; k++) begin
                checks++;
                if (acc_cyc[b][k] - acc_cyc[b][k-1] !== lat_b[b] + 2) begin
                    errors++; $display("FAIL lat%0d_spacing%0d got %0d exp %0d", lat_b[b], k,
                                       acc_cyc[b][k] - acc_cyc[b][k-1], lat_b[b] + 2);
                end
            end
            for (int k = 0; k < rsp_n[b] && k < acc_n[b]; k++) begin
                checks++;
                if (rsp_d[b][k] !== fmem(acc_addr[b][k])) begin
                    errors++; $display("FAIL lat%0d_data%0d got %h exp %h", lat_b[b], k,
                                       rsp_d[b][k], fmem(acc_addr[b][k]));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h0; req_wdata = 32'h0;
        rsp_ready = 1'b0; fr_go = 1'b0; fr_addr = 8'h0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            mem_arr[i] = ref_mem[i];
        end
        ref_mem[5] = 32'h12345678;
        mem_arr[5] = 32'h12345678;

        test_reset();
        test_write_read();
        test_backpressure();
        test_boundary();
        test_reset_async();
        test_reset_mid_read();
        test_random();
        test_latency_builds();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Initiator-side controller that drives the simple dual-address memory port: write_enable/read_enable, write_addr/read_addr, write_data in; read_data out.
- Accepts single requests from a processor-side valid/ready channel and sequences them onto the memory port.
- Holds each read for the memory's fixed read LATENCY, captures the data and returns it on a valid/ready response channel.
- Sits between a core load/store stage and the memory instance.

Parameters:
- N, 256, memory depth; address width AW = $clog2(N).
- M, 32, data width.
- LATENCY, 2, read latency in cycles. Legal range is 1..15; elaboration error outside that range.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  request address.
- req_wdata  in  M  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes read data.
- rsp_rdata  out  M  read data.
- mem_write_enable  out  1  to memory write_enable.
- mem_write_addr  out  AW  to memory write_addr.
- mem_write_data  out  M  to memory write_data.
- mem_read_enable  out  1  to memory read_enable.
- mem_read_addr  out  AW  to memory read_addr.
- mem_read_data  in  M  from memory read_data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - state = IDLE, latency counter = 0.
  - All address/data holding registers and rsp_rdata = 0.
  - mem_write_enable, mem_read_enable, rsp_valid and busy = 0.
  - req_ready = 0 while rst is high.
- States: IDLE, WRITE, READ, RESP. req_ready = (state == IDLE) && !rst.
- IDLE: on req_valid && req_ready, latch req_addr and req_wdata. If req_we = 1, go to WRITE. Otherwise load counter = LATENCY-1 and go to READ.
- WRITE (exactly 1 cycle):
  - mem_write_enable = 1, mem_write_addr/mem_write_data from latches.
  - Return to IDLE. Writes produce no response.
  - Throughput is one write per 2 cycles.
- READ (exactly LATENCY cycles):
  - mem_read_enable = 1, mem_read_addr held constant from latch.
  - Counter decrements each cycle.
  - In the cycle where counter == 0, capture mem_read_data into rsp_rdata on the clock edge and go to RESP.
- RESP:
  - rsp_valid = 1, mem_read_enable = 0.
  - rsp_rdata stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE; rsp_valid falls next cycle.
- Timing: a read accepted at edge T0 gives rsp_valid high in the cycle after edge T0+LATENCY. With rsp_ready held high, the next request can be accepted at edge T0+LATENCY+2.
- Enables are decoded from registered state; no combinational path from req_* to mem_*.
- Address/data outputs keep their last values when enables are low.
- Read after write: a write always finishes its WRITE cycle before the next request is accepted, so a following read of the same address returns the new data.
- rsp_ready asserted outside RESP is ignored. req_* inputs are ignored outside IDLE, and need not stay stable once accepted.
- Reset during READ or RESP aborts the transaction: enables drop and rsp_valid drops immediately (asynchronous), and no response is delivered.
- Addresses are used unmodified; 0 and N-1 are ordinary addresses with no wrap logic.

Decomposition:
- Shared package mem_pkg holds:
  - typedef enum logic [1:0] mem_ctrl_state_t {IDLE, WRITE, READ, RESP};
  - default constants MEM_DEPTH = 256, MEM_WIDTH = 32, MEM_LATENCY = 2.
- No sub-module needed; the latency down-counter stays inline.
- The testbench instantiates mem_req_ctrl together with the memory instance.

Test Plan:
- Reset values: assert rst mid-simulation → all outputs 0 the same cycle; after deassert, req_ready = 1 and busy = 0.
- Write then read: write 0x10 ← 0xDEADBEEF, then read 0x10 → rsp_rdata = 0xDEADBEEF. mem_read_enable is high exactly 2 cycles; rsp_valid is high in the cycle after edge T0+2.
- Backpressure: read 0x05 (preloaded 0x12345678) with rsp_ready low for 3 cycles → rsp_valid and rsp_rdata stay constant and req_ready stays 0; raising rsp_ready gives exactly one handshake.
- Boundary addresses: write 0xFF ← 0xA5A5A5A5 and 0x00 ← 0x5A5A5A5A, then read both → values are distinct and correct, with no aliasing.
- Reset mid-read: assert rst during the second READ cycle → mem_read_enable and busy drop immediately and no rsp_valid occurs; a fresh read afterwards completes normally.
- LATENCY = 1 and LATENCY = 4 builds: back-to-back reads with rsp_ready tied high → accept-to-accept spacing of 3 and 6 cycles respectively.
